nios_sys_pio_buttons: RTL and testbench

//  Avalon-MM slave input PIO: the input-direction counterpart of the LED output PIO.

---
 rtl/nios_sys_pio_buttons.sv | 99 +++++++++
 tb/tb_nios_sys_pio_buttons.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sys_pio_buttons.sv
// Avalon-MM input PIO: synchronizes external button/switch lines, captures edges
// in a write-1-to-clear register and raises a maskable level interrupt.
module nios_sys_pio_buttons #(
  parameter int          WIDTH       = 4,
  parameter int          EDGE_TYPE   = 1,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] delay_q;
  logic [WIDTH-1:0] edgeCapture_q, edgeCapture_d;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] syncOut;
  logic [WIDTH-1:0] edgeDet;
  logic [WIDTH-1:0] clearBits;
  logic             wrEn;
  logic             unused_wdata;

  assign syncOut      = sync_q[SYNC_STAGES-1];
  assign wrEn         = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edgeDet = syncOut & ~delay_q;
      1:       edgeDet = ~syncOut & delay_q;
      default: edgeDet = syncOut ^ delay_q;
    endcase
  end

  // A new edge on the same cycle as a W1C keeps the bit set so no edge is lost.
  always_comb begin
    clearBits = '0;
    if (wrEn && address == ADDR_EDGE) begin
      clearBits = writedata[WIDTH-1:0];
    end
    edgeCapture_d = (edgeCapture_q & ~clearBits) | edgeDet;

    irqMask_d = irqMask_q;
    if (wrEn && address == ADDR_MASK) begin
      irqMask_d = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = syncOut;
      ADDR_DIR:  readdata_d = '0;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irqMask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edgeCapture_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      delay_q       <= '0;
      edgeCapture_q <= '0;
      irqMask_q     <= RESET_MASK[WIDTH-1:0];
      readdata_q    <= '0;
    end else begin
      sync_q        <= sync_d;
      delay_q       <= syncOut;
      edgeCapture_q <= edgeCapture_d;
      irqMask_q     <= irqMask_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgeCapture_q & irqMask_q);

endmodule

// File: tb/tb_nios_sys_pio_buttons.sv
// Directed bench for nios_sys_pio_buttons: a falling-edge instance and a
// rising-edge instance share the bus, each with its own input lines.
module tb_nios_sys_pio_buttons;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  inF;
  logic [3:0]  inR;
  logic [31:0] readdataF;
  logic [31:0] readdataR;
  logic        irqF;
  logic        irqR;

  int checks;
  int failures;

  nios_sys_pio_buttons #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2), .RESET_MASK(32'h0)) dutF (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(inF),
    .readdata(readdataF), .irq(irqF)
  );

  nios_sys_pio_buttons #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .RESET_MASK(32'h0)) dutR (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(inR),
    .readdata(readdataR), .irq(irqR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Every step ends 1 time unit after a rising edge; inputs change and outputs are sampled there.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] vF, output logic [31:0] vR);
    address = a;
    tick(1);
    vF = readdataF;
    vR = readdataR;
  endtask

  task automatic test_reset;
    logic [31:0] vF, vR;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    busRead(2'd0, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", vF, 32'h0); end
    busRead(2'd2, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL reset_mask got=%h exp=%h", vF, 32'h0); end
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h0 || vR !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_edge got=%h/%h exp=0/0", vF, vR);
    end
    checks++;
    if (irqF !== 1'b0 || irqR !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_irq got=%b/%b exp=0/0", irqF, irqR);
    end
  endtask

  task automatic test_rising;
    logic [31:0] vF, vR;
    address = 2'd0;
    inR = 4'b0101;
    tick(2);
    checks++;
    if (readdataR !== 32'h0) begin failures++; $display("[TB] FAIL rise_data_early got=%h exp=%h", readdataR, 32'h0); end
    tick(1);
    checks++;
    if (readdataR !== 32'h5) begin failures++; $display("[TB] FAIL rise_data got=%h exp=%h", readdataR, 32'h5); end
    busRead(2'd3, vF, vR);
    checks++;
    if (vR !== 32'h5) begin failures++; $display("[TB] FAIL rise_edge got=%h exp=%h", vR, 32'h5); end
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL rise_edge_on_fall_inst got=%h exp=%h", vF, 32'h0); end
  endtask

  task automatic test_falling_irq;
    logic [31:0] vF, vR;
    inF = 4'b0100;
    tick(4);
    busWrite(2'd2, 32'hF);
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL fall_no_capture_on_rise got=%h exp=%h", vF, 32'h0); end
    inF = 4'b0000;
    tick(2);
    checks++;
    if (irqF !== 1'b0) begin failures++; $display("[TB] FAIL fall_irq_early got=%b exp=0", irqF); end
    tick(1);
    checks++;
    if (irqF !== 1'b1) begin failures++; $display("[TB] FAIL fall_irq got=%b exp=1", irqF); end
    busWrite(2'd3, 32'h4);
    checks++;
    if (irqF !== 1'b0) begin failures++; $display("[TB] FAIL w1c_irq got=%b exp=0", irqF); end
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL w1c_edge got=%h exp=%h", vF, 32'h0); end
  endtask

  task automatic test_mask;
    logic [31:0] vF, vR;
    busWrite(2'd2, 32'h0);
    inF = 4'b0001;
    tick(4);
    inF = 4'b0000;
    tick(3);
    checks++;
    if (irqF !== 1'b0) begin failures++; $display("[TB] FAIL masked_irq got=%b exp=0", irqF); end
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h1) begin failures++; $display("[TB] FAIL masked_edge got=%h exp=%h", vF, 32'h1); end
    busWrite(2'd2, 32'hFFFF_FFF1);
    checks++;
    if (irqF !== 1'b1) begin failures++; $display("[TB] FAIL unmask_irq got=%b exp=1", irqF); end
    busRead(2'd2, vF, vR);
    checks++;
    if (vF !== 32'h1) begin failures++; $display("[TB] FAIL mask_readback got=%h exp=%h", vF, 32'h1); end
    busWrite(2'd2, 32'h0);
    busRead(2'd3, vF, vR);
    checks++;
    if (irqF !== 1'b0 || vF !== 32'h1) begin
      failures++; $display("[TB] FAIL remask got irq=%b edge=%h exp irq=0 edge=1", irqF, vF);
    end
    busWrite(2'd3, 32'h1);
    busWrite(2'd2, 32'hF);
  endtask

  task automatic test_set_wins;
    logic [31:0] vF, vR;
    inF = 4'b0010;
    tick(4);
    inF = 4'b0000;
    tick(2);
    busWrite(2'd3, 32'h2);
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h2) begin failures++; $display("[TB] FAIL set_wins_edge got=%h exp=%h", vF, 32'h2); end
    checks++;
    if (irqF !== 1'b1) begin failures++; $display("[TB] FAIL set_wins_irq got=%b exp=1", irqF); end
    busWrite(2'd3, 32'h2);
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL plain_w1c got=%h exp=%h", vF, 32'h0); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] vF, vR;
    inF = 4'b0100;
    tick(4);
    inF = 4'b0000;
    tick(3);
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h4 || irqF !== 1'b1) begin
      failures++; $display("[TB] FAIL premid_capture got edge=%h irq=%b exp edge=4 irq=1", vF, irqF);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (irqF !== 1'b0 || readdataF !== 32'h0) begin
      failures++; $display("[TB] FAIL async_reset got irq=%b rd=%h exp irq=0 rd=0", irqF, readdataF);
    end
    tick(1);
    reset_n = 1'b1;
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL postreset_edge got=%h exp=%h", vF, 32'h0); end
    busRead(2'd2, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL postreset_mask got=%h exp=%h", vF, 32'h0); end
    inF = 4'b0101;
    tick(4);
    busWrite(2'd0, 32'hFFFF_FFFF);
    busWrite(2'd1, 32'hFFFF_FFFF);
    busRead(2'd0, vF, vR);
    checks++;
    if (vF !== 32'h5) begin failures++; $display("[TB] FAIL ro_data got=%h exp=%h", vF, 32'h5); end
    busRead(2'd1, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL ro_dir got=%h exp=%h", vF, 32'h0); end
    busRead(2'd2, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL ro_mask got=%h exp=%h", vF, 32'h0); end
    busRead(2'd3, vF, vR);
    checks++;
    if (vF !== 32'h0) begin failures++; $display("[TB] FAIL ro_edge got=%h exp=%h", vF, 32'h0); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    inF        = 4'b0000;
    inR        = 4'b0000;
    $display("[TB] starting");
    test_reset();
    test_rising();
    test_falling_irq();
    test_mask();
    test_set_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
